// File: rtl/uart_tx_engine.sv
// UART transmitter with a word FIFO in front of a start/data/parity/stop serialiser.
// Frames go out back-to-back: the end of a stop bit pops the next queued word directly into START.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 50,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          UART_clk,
  input  logic                          reset_b,
  input  logic                          TX_en,
  input  logic [DATA_BITS-1:0]          Word_To_Send,
  output logic                          TX_Ready,
  output logic                          TX_Busy,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count,
  output logic                          RsTx
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam int BIW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] BAUD_TC   = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] LAST_BIT  = BIW'(DATA_BITS - 1);
  localparam logic [AW:0]    FULL      = (AW + 1)'(FIFO_DEPTH);
  localparam logic           LAST_STOP = (STOP_BITS == 2);
  localparam logic           ODD       = (PARITY_MODE == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  state_t               r_state, w_state_n;
  logic [BCW-1:0]       r_baud, w_baud_n;
  logic [BIW-1:0]       r_bit, w_bit_n;
  logic                 r_stop, w_stop_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_par, w_par_n;
  logic                 r_tx, w_tx_n;
  logic                 r_busy;
  logic                 w_push, w_pop, w_tc, w_avail;
  logic [DATA_BITS-1:0] w_head;

  assign TX_Ready   = (r_count != FULL);
  assign TX_Busy    = r_busy;
  assign FIFO_Count = r_count;
  assign RsTx       = r_tx;

  assign w_push  = TX_en & TX_Ready;
  assign w_avail = (r_count != '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_tc    = (r_baud == BAUD_TC);

  always_ff @(posedge UART_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= Word_To_Send;
  end

  // Depth is a power of two, so the pointers wrap on natural overflow
  always_ff @(posedge UART_clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = w_tc ? '0 : r_baud + BCW'(1);
    w_bit_n   = r_bit;
    w_stop_n  = r_stop;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_pop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_baud_n = '0;
        if (w_avail) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_par_n   = (^w_head) ^ ODD;
          w_bit_n   = '0;
          w_stop_n  = 1'b0;
          w_state_n = S_START;
        end
      end
      S_START: if (w_tc) w_state_n = S_DATA;
      S_DATA: begin
        if (w_tc) begin
          w_shift_n = r_shift >> 1;
          if (r_bit == LAST_BIT) begin
            w_bit_n   = '0;
            w_state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_n = r_bit + BIW'(1);
          end
        end
      end
      S_PARITY: if (w_tc) w_state_n = S_STOP;
      S_STOP: begin
        if (w_tc) begin
          if (r_stop == LAST_STOP) begin
            w_stop_n = 1'b0;
            // Chain straight into the next frame when a word is waiting
            if (w_avail) begin
              w_pop     = 1'b1;
              w_shift_n = w_head;
              w_par_n   = (^w_head) ^ ODD;
              w_bit_n   = '0;
              w_state_n = S_START;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_stop_n = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Line level is decoded from the next state so RsTx comes straight from a flop
    case (w_state_n)
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_shift_n[0];
      S_PARITY: w_tx_n = w_par_n;
      default:  w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge UART_clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_stop  <= w_stop_n;
      r_tx    <= w_tx_n;
      r_busy  <= (w_state_n != S_IDLE);
    end
  end

  always_ff @(posedge UART_clk) begin
    r_shift <= w_shift_n;
    r_par   <= w_par_n;
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: five parameter variants share one clock and reset;
// directed writes queue the expected frames and per-instance line monitors decode and compare them.
module tb_uart_tx_engine;

  localparam int CPB [5] = '{50, 50, 50, 50, 2};
  localparam int DB  [5] = '{8, 8, 8, 8, 5};
  localparam int PM  [5] = '{0, 1, 2, 0, 0};
  localparam int SB  [5] = '{1, 1, 1, 2, 1};

  typedef struct packed {
    logic [8:0] word;
    logic       par;
    logic       b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] en;
  logic [7:0] wd [5];
  logic [4:0] tx, busy, rdy;
  logic [2:0] cnt [5];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  exp_t q0[$], q1[$], q2[$], q3[$], q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_engine #(.CLKS_PER_BIT(50), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .UART_clk(clk), .reset_b(rst_n), .TX_en(en[0]), .Word_To_Send(wd[0]),
    .TX_Ready(rdy[0]), .TX_Busy(busy[0]), .FIFO_Count(cnt[0]), .RsTx(tx[0]));
  uart_tx_engine #(.CLKS_PER_BIT(50), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .UART_clk(clk), .reset_b(rst_n), .TX_en(en[1]), .Word_To_Send(wd[1]),
    .TX_Ready(rdy[1]), .TX_Busy(busy[1]), .FIFO_Count(cnt[1]), .RsTx(tx[1]));
  uart_tx_engine #(.CLKS_PER_BIT(50), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .UART_clk(clk), .reset_b(rst_n), .TX_en(en[2]), .Word_To_Send(wd[2]),
    .TX_Ready(rdy[2]), .TX_Busy(busy[2]), .FIFO_Count(cnt[2]), .RsTx(tx[2]));
  uart_tx_engine #(.CLKS_PER_BIT(50), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .UART_clk(clk), .reset_b(rst_n), .TX_en(en[3]), .Word_To_Send(wd[3]),
    .TX_Ready(rdy[3]), .TX_Busy(busy[3]), .FIFO_Count(cnt[3]), .RsTx(tx[3]));
  uart_tx_engine #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
    .UART_clk(clk), .reset_b(rst_n), .TX_en(en[4]), .Word_To_Send(wd[4][4:0]),
    .TX_Ready(rdy[4]), .TX_Busy(busy[4]), .FIFO_Count(cnt[4]), .RsTx(tx[4]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] w, input logic p, input logic b);
    exp_t e;
    e.word = w;
    e.par  = p;
    e.b2b  = b;
    return e;
  endfunction

  function automatic void push_exp(input int idx, input exp_t e);
    case (idx)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q3.push_back(e);
      default: q4.push_back(e);
    endcase
  endfunction

  function automatic int q_size(input int idx);
    case (idx)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      3: return q3.size();
      default: return q4.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(input int idx);
    case (idx)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      3: return q3.pop_front();
      default: return q4.pop_front();
    endcase
  endfunction

  // Decodes each frame on one instance's line, checking every cycle of every bit cell
  task automatic monitor(input int idx);
    int         prev_end;
    int         start;
    int         nb;
    bit         have, aborted, st;
    logic       v0;
    exp_t       e;
    logic [15:0] exp_bits, got, stb;
    prev_end = -100;
    forever begin
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx[idx] === 1'b0) break;
      end
      start = cyc;
      have = (q_size(idx) != 0);
      check($sformatf("u%0d_frame_queued", idx), {31'd0, have}, 32'd1);
      e = have ? pop_exp(idx) : '0;
      nb = 1 + DB[idx] + ((PM[idx] != 0) ? 1 : 0) + SB[idx];
      exp_bits = '1;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < DB[idx]; i++) exp_bits[1 + i] = e.word[i];
      if (PM[idx] != 0) exp_bits[1 + DB[idx]] = e.par;
      got = '0;
      stb = '0;
      aborted = 1'b0;
      v0 = 1'b0;
      for (int b = 0; b < nb; b++) begin
        st = 1'b1;
        for (int c = 0; c < CPB[idx]; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (c == 0) v0 = tx[idx];
          else if (tx[idx] !== v0) st = 1'b0;
        end
        if (aborted) break;
        got[b] = v0;
        stb[b] = st;
      end
      if (aborted) begin
        prev_end = -100;
      end else begin
        if (have) begin
          for (int b = 0; b < nb; b++)
            check($sformatf("u%0d_w%0h_bit%0d", idx, e.word, b), {30'd0, stb[b], got[b]}, {30'd0, 1'b1, exp_bits[b]});
          if (e.b2b) check($sformatf("u%0d_w%0h_gap", idx, e.word), start - prev_end, 32'd1);
        end
        prev_end = cyc;
      end
    end
  endtask

  task automatic wr(input int idx, input logic [7:0] d);
    en[idx] = 1'b1;
    wd[idx] = d;
    @(negedge clk);
    en[idx] = 1'b0;
  endtask

  task automatic measure(input int idx, input int exp_len, input string name, input bit pre_wait);
    int n;
    n = 0;
    if (pre_wait) @(negedge clk);
    while (busy[idx] === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check(name, n, exp_len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  line_ok;
    rst_n = 1'b0;
    en = '0;
    for (int i = 0; i < 5; i++) wd[i] = '0;
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
      monitor(4);
    join_none

    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("u%0d_rst_tx", i), tx[i], 1);
      check($sformatf("u%0d_rst_busy", i), busy[i], 0);
      check($sformatf("u%0d_rst_cnt", i), cnt[i], 0);
      check($sformatf("u%0d_rst_rdy", i), rdy[i], 1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 single word and write-to-start latency
    push_exp(0, mk(9'h0A5, 1'b0, 1'b0));
    wr(0, 8'hA5);
    check("u0_lat_cnt1", cnt[0], 1);
    check("u0_lat_tx_still_high", tx[0], 1);
    @(negedge clk);
    check("u0_lat_tx_low", tx[0], 0);
    check("u0_lat_busy", busy[0], 1);
    check("u0_lat_cnt0", cnt[0], 0);
    measure(0, 500, "u0_frame_len", 1'b0);
    check("u0_idle_tx", tx[0], 1);
    repeat (3) @(negedge clk);

    // Even then odd parity on 0x07
    push_exp(1, mk(9'h007, 1'b1, 1'b0));
    wr(1, 8'h07);
    measure(1, 550, "u1_frame_len", 1'b1);
    push_exp(2, mk(9'h007, 1'b0, 1'b0));
    wr(2, 8'h07);
    measure(2, 550, "u2_frame_len", 1'b1);
    repeat (3) @(negedge clk);

    // Overflow: one frame in flight, then five writes into a depth-4 FIFO
    push_exp(0, mk(9'h0FF, 1'b0, 1'b0));
    wr(0, 8'hFF);
    repeat (3) @(negedge clk);
    check("u0_ovf_busy", busy[0], 1);
    for (int i = 1; i <= 4; i++) push_exp(0, mk(9'(i), 1'b0, 1'b1));
    wr(0, 8'h01);
    wr(0, 8'h02);
    wr(0, 8'h03);
    check("u0_ovf_rdy_at3", rdy[0], 1);
    wr(0, 8'h04);
    check("u0_ovf_rdy_full", rdy[0], 0);
    check("u0_ovf_cnt_full", cnt[0], 4);
    wr(0, 8'h05);
    check("u0_ovf_cnt_drop", cnt[0], 4);
    n = 0;
    while (cnt[0] == 3'd4 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("u0_ovf_cnt_after_pop", cnt[0], 3);
    check("u0_ovf_rdy_after_pop", rdy[0], 1);
    n = 0;
    while (busy[0] === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("u0_ovf_drained", busy[0], 0);
    check("u0_ovf_queue_empty", q_size(0), 0);
    repeat (3) @(negedge clk);

    // Two stop bits, back-to-back words
    push_exp(3, mk(9'h000, 1'b0, 1'b0));
    push_exp(3, mk(9'h0FF, 1'b0, 1'b1));
    wr(3, 8'h00);
    wr(3, 8'hFF);
    measure(3, 1100, "u3_two_frames_len", 1'b0);

    // Minimum baud divisor, 5-bit word
    push_exp(4, mk(9'h01F, 1'b0, 1'b0));
    wr(4, 8'h1F);
    measure(4, 14, "u4_frame_len", 1'b1);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 with two words queued
    push_exp(0, mk(9'h033, 1'b0, 1'b0));
    wr(0, 8'h33);
    wr(0, 8'h44);
    wr(0, 8'h55);
    repeat (210) @(negedge clk);
    check("u0_pre_rst_cnt", cnt[0], 2);
    check("u0_pre_rst_tx_bit3", tx[0], 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("u0_async_rst_tx", tx[0], 1);
    check("u0_async_rst_cnt", cnt[0], 0);
    check("u0_async_rst_busy", busy[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    line_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || cnt[0] !== 3'd0 || busy[0] !== 1'b0) line_ok = 1'b0;
    end
    check("u0_post_rst_idle", {31'd0, line_ok}, 1);

    for (int i = 1; i < 5; i++) check($sformatf("u%0d_queue_empty", i), q_size(i), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised UART transmitter with an internal word FIFO, clocked from the UART clock domain. It replaces the fixed 8N1, 115200-baud transmit datapath/controller pair with a single block. Baud divisor, data width, parity mode, stop-bit count and FIFO depth are configurable. Producers push words through a ready/valid-style write port, and the block serialises them onto the RS232 output back-to-back with no idle gaps.

## Interface
- CLKS_PER_BIT, 50: UART_clk cycles per bit (5.76 MHz / 115200). Legal range ≥ 2.
- DATA_BITS, 8: payload bits per frame. Legal range 5–9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: word FIFO depth. Must be a power of 2, ≥ 2.
- UART_clk  input  1  UART clock, 5.76 MHz nominal; all logic on its rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- TX_en  input  1  write strobe; pushes Word_To_Send when TX_Ready = 1.
- Word_To_Send  input  DATA_BITS  word to transmit, LSB sent first.
- TX_Ready  output  1  FIFO not full; combinational from FIFO count.
- TX_Busy  output  1  a frame is being shifted out (FSM not IDLE).
- FIFO_Count  output  $clog2(FIFO_DEPTH)+1  words currently queued, excluding the frame in flight.
- RsTx  output  1  serial line to the RS232 peripheral; idles high.

## Operation
- **Reset values:**
  - RsTx = 1; TX_Busy = 0; FIFO_Count = 0; TX_Ready = 1.
  - FSM = IDLE; baud counter = 0; bit index = 0.
- **FIFO:**
  - A write occurs on an edge where TX_en & TX_Ready.
  - TX_en while full is ignored: the word is dropped and no state changes.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: RsTx = 1. If FIFO non-empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: RsTx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: RsTx = shift[0] for CLKS_PER_BIT cycles per bit, shifting right. After DATA_BITS bits, go to PARITY if PARITY_MODE ≠ 0, else STOP.
  - PARITY: RsTx = XOR of the word for even parity, or its complement for odd, for CLKS_PER_BIT cycles. Parity is computed at the pop.
  - STOP: RsTx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - End of STOP with FIFO non-empty: pop and go directly to START on the same edge. No idle cycle is inserted.
  - End of STOP with FIFO empty: go to IDLE.
- **Baud counter:**
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0 … CLKS_PER_BIT−1 and wraps to 0 at the terminal count.
  - Held at 0 in IDLE.
- TX_Busy = (state ≠ IDLE).
- All outputs except TX_Ready are registered. RsTx must be a flop output with no glitches.
- Asserting reset_b low mid-frame aborts the frame immediately: RsTx = 1 and the FIFO is emptied. Queued words are lost.

## Timing
- **Frame length:** F = (1 + DATA_BITS + (PARITY_MODE ≠ 0) + STOP_BITS) × CLKS_PER_BIT cycles, exactly.
- **Write-to-start latency**, with the FIFO empty and the FSM idle:
  - Word written on edge N.
  - Popped on edge N+1; RsTx falls after edge N+1.
  - FIFO_Count reads 1 for one cycle, then 0.
- **Back-to-back frames:** k queued words occupy exactly k × F cycles of continuous line activity.
- **TX_Ready** deasserts in the cycle after the write that makes the count reach FIFO_DEPTH. It reasserts in the cycle after the next pop.

## Test plan
- **8N1 single word:** defaults, write 0xA5 → RsTx pattern 0,1,0,1,0,0,1,0,1,1, each bit held 50 cycles. RsTx falls 1 cycle after the write, and TX_Busy deasserts 500 cycles after the start.
- **Even and odd parity:** PARITY_MODE = 1, write 0x07 → parity bit 1, frame 550 cycles. PARITY_MODE = 2 with the same word → parity bit 0.
- **Overflow:** with the FSM busy, write 5 words 0x01–0x05 back-to-back → TX_Ready low after the 4th, 0x05 dropped. Exactly 0x01–0x04 are transmitted, with no gaps between frames.
- **Back-to-back with 2 stop bits:** STOP_BITS = 2, write 0x00 and 0xFF on consecutive cycles → 1100 contiguous cycles of activity, and the second start bit immediately follows 100 high cycles.
- **Reset mid-frame:** pull reset_b low during DATA bit 3 with 2 words queued → RsTx = 1 and FIFO_Count = 0 asynchronously. After release, the line stays idle until a new write.
- **Parameter corner:** CLKS_PER_BIT = 2, DATA_BITS = 5, write 0x1F → frame of 14 cycles, pattern 0,1,1,1,1,1,1.
